// File: rtl/hamming_pkg.sv
// hamming_pkg: shared types, flag codes and codeword geometry helpers for hamming_engine
package hamming_pkg;

  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

  typedef enum logic {MODE_ENC, MODE_DEC} mode_t;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_SEC = 2'b01;
  localparam logic [1:0] FLAG_DED = 2'b10;

  function automatic int calc_r(input int dw);
    int r;
    r = 0;
    while ((1 << r) < dw + r + 1) r = r + 1;
    return r;
  endfunction

  function automatic int calc_cw(input int dw);
    return dw + calc_r(dw) + 1;
  endfunction

  function automatic int calc_bytes(input int dw);
    return calc_cw(dw) / 8;
  endfunction

  function automatic logic is_pow2(input int v);
    return (v & (v - 1)) == 0;
  endfunction

endpackage

// File: rtl/hamming_codec.sv
// hamming_codec: combinational SECDED encode, syndrome, single-bit correction and data extraction
module hamming_codec import hamming_pkg::*; #(
  parameter int DATA_W = 11
) (
  input  logic [DATA_W-1:0]          data,
  input  logic [calc_cw(DATA_W)-1:0] cw_in,
  output logic [calc_cw(DATA_W)-1:0] enc_cw,
  output logic [DATA_W-1:0]          dec_data,
  output logic [1:0]                 flag
);

  localparam int R    = calc_r(DATA_W);
  localparam int CW_W = calc_cw(DATA_W);

  logic [R-1:0]    syn;
  logic            tot;
  logic [CW_W-1:0] fixed;

  // scatter data into non-power-of-two slots, then fill Hamming parities and overall parity at bit 0
  always_comb begin
    int j;
    enc_cw = '0;
    j = 0;
    for (int q = 1; q < CW_W; q++)
      if (!is_pow2(q)) begin
        enc_cw[q] = data[j];
        j = j + 1;
      end
    for (int i = 0; i < R; i++)
      for (int q = 1; q < CW_W; q++)
        if (q != (1 << i) && (q & (1 << i)) != 0) enc_cw[1 << i] = enc_cw[1 << i] ^ enc_cw[q];
    enc_cw[0] = ^enc_cw[CW_W-1:1];
  end

  // odd total parity means one flipped bit (at the syndrome position, bit 0 if syndrome is zero); even parity with a syndrome means two
  always_comb begin
    int k;
    syn = '0;
    for (int q = 1; q < CW_W; q++)
      if (cw_in[q]) syn = syn ^ R'(q);
    tot = ^cw_in;
    fixed = tot ? cw_in ^ (CW_W'(1) << syn) : cw_in;
    flag = tot ? FLAG_SEC : (syn != '0) ? FLAG_DED : FLAG_OK;
    dec_data = '0;
    k = 0;
    for (int q = 1; q < CW_W; q++)
      if (!is_pow2(q)) begin
        dec_data[k] = fixed[q];
        k = k + 1;
      end
  end

endmodule

// File: rtl/hamming_engine.sv
// hamming_engine: memory-to-memory SECDED encoder/decoder; HAMMING_ERR_STATS_EN enables saturating decode error counters
module hamming_engine import hamming_pkg::*; #(
  parameter int DATA_W   = 11,
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mode,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        err_single_cnt,
  output logic [7:0]        err_double_cnt
);

  localparam int         CW_W     = calc_cw(DATA_W);
  localparam int         BYTES    = calc_bytes(DATA_W);
  localparam logic [2:0] RD_LAST  = 3'(BYTES);
  localparam logic [2:0] WR_LAST  = 3'(BYTES - 1);
  localparam logic [6:0] MSG_LAST = 7'(NUM_MSG - 1);

  state_t          state;
  mode_t           mode_q;
  logic [2:0]      cnt;
  logic [6:0]      msg;
  logic [CW_W-1:0] cw, wbuf, enc_cw, dec_word, word;
  logic [DATA_W-1:0] dec_data;
  logic [1:0]      flag;
  logic            start;

  function automatic logic [ADDR_W-1:0] msg_addr(input int base, input logic [6:0] m);
    return ADDR_W'(base + BYTES * int'(m));
  endfunction

  hamming_codec #(.DATA_W(DATA_W)) u_codec (
    .data     (cw[DATA_W-1:0]),
    .cw_in    (cw),
    .enc_cw   (enc_cw),
    .dec_data (dec_data),
    .flag     (flag)
  );

  assign start    = (state == IDLE || state == DONE) && req;
  assign dec_word = CW_W'(dec_data) | (CW_W'(flag) << (CW_W - 2));
  assign word     = (mode_q == MODE_DEC) ? dec_word : enc_cw;

  // sequencer: READ issues BYTES addresses and spends one extra cycle catching the last byte, CALC latches the result, WRITE streams it out LSB first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode_q    <= MODE_ENC;
      cnt       <= '0;
      msg       <= '0;
      cw        <= '0;
      wbuf      <= '0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state    <= READ;
          mode_q   <= mode_t'(mode);
          cnt      <= '0;
          msg      <= '0;
          done     <= 1'b0;
          mem_addr <= msg_addr(SRC_BASE, 7'd0);
        end
        READ: begin
          if (cnt != '0) cw <= (cw >> 8) | (CW_W'(mem_rdata) << (CW_W - 8));
          mem_addr <= mem_addr + ADDR_W'(1);
          if (cnt == RD_LAST) begin
            state <= CALC;
            cnt   <= '0;
          end else cnt <= cnt + 3'd1;
        end
        CALC: begin
          state     <= WRITE;
          cnt       <= '0;
          wbuf      <= word >> 8;
          mem_wdata <= word[7:0];
          mem_wr_en <= 1'b1;
          mem_addr  <= msg_addr(DST_BASE, msg);
        end
        WRITE: if (cnt == WR_LAST) begin
          mem_wr_en <= 1'b0;
          mem_wdata <= '0;
          cnt       <= '0;
          if (msg == MSG_LAST) begin
            state    <= DONE;
            done     <= 1'b1;
            mem_addr <= '0;
          end else begin
            state    <= READ;
            msg      <= msg + 7'd1;
            mem_addr <= msg_addr(SRC_BASE, msg + 7'd1);
          end
        end else begin
          cnt       <= cnt + 3'd1;
          mem_addr  <= mem_addr + ADDR_W'(1);
          mem_wdata <= wbuf[7:0];
          wbuf      <= wbuf >> 8;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAMMING_ERR_STATS_EN
  // per-run decode error tallies, cleared on each accepted start and saturating at 255
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_single_cnt <= '0;
      err_double_cnt <= '0;
    end else if (start) begin
      err_single_cnt <= '0;
      err_double_cnt <= '0;
    end else if (state == CALC && mode_q == MODE_DEC) begin
      if (flag == FLAG_SEC && err_single_cnt != 8'hFF) err_single_cnt <= err_single_cnt + 8'd1;
      if (flag == FLAG_DED && err_double_cnt != 8'hFF) err_double_cnt <= err_double_cnt + 8'd1;
    end
  end
`else
  assign err_single_cnt = '0;
  assign err_double_cnt = '0;
`endif

endmodule
